// File: rtl/arm_pkg.sv
// Shared constants for the ARM-subset core: execute commands, opcodes,
// condition codes, instruction modes, status bit positions and the control bundle.
package arm_pkg;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_UND = 2'b11;

  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

  typedef struct packed {
    logic [3:0] exec_cmd;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
    logic       b;
    logic       s;
    logic       imm;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_control_cond_check.sv
// Combinational ARM condition-field evaluation against an NZCV nibble.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign n = nzcv[ST_N];
  assign z = nzcv[ST_Z];
  assign c = nzcv[ST_C];
  assign v = nzcv[ST_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_ex_control.sv
// ID-stage decode, NZCV status register and ID/EX pipeline register.
// Define ID_FLAG_FWD_EN to evaluate conditions on same-cycle ALU flags when ex_s=1.
module id_ex_control
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] pc_in,
  input  logic        freeze,
  input  logic        flush,
  input  logic        ex_s,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  output logic [3:0]  ex_exec_cmd,
  output logic        ex_mem_r_en,
  output logic        ex_mem_w_en,
  output logic        ex_wb_en,
  output logic        ex_b,
  output logic        ex_s_out,
  output logic        ex_imm,
  output logic [11:0] ex_shift_operand,
  output logic [23:0] ex_imm24,
  output logic [3:0]  ex_dest,
  output logic [3:0]  ex_rn,
  output logic [3:0]  ex_rm,
  output logic [31:0] ex_pc,
  output logic [3:0]  status,
  output logic        c_in
);

  logic [3:0]  status_q;
  logic [3:0]  alu_flags;
  logic [3:0]  cond_flags;
  logic        cond_pass;
  ctrl_t       ctrl_dec, ctrl_d, ctrl_q;
  logic [11:0] shift_q;
  logic [23:0] imm24_q;
  logic [3:0]  dest_q, rn_q, rm_q;
  logic [31:0] pc_q;

  assign alu_flags = {alu_n, alu_z, alu_c, alu_v};

`ifdef ID_FLAG_FWD_EN
  assign cond_flags = ex_s ? alu_flags : status_q;
`else
  assign cond_flags = status_q;
`endif

  cond_check u_cond_check (
    .cond (instr[31:28]),
    .nzcv (cond_flags),
    .pass (cond_pass)
  );

  always_comb begin
    ctrl_dec = CTRL_BUBBLE;
    case (instr[27:26])
      MODE_DP: begin
        ctrl_dec.imm   = instr[25];
        ctrl_dec.s     = instr[20];
        ctrl_dec.wb_en = 1'b1;
        case (instr[24:21])
          OP_MOV: ctrl_dec.exec_cmd = CMD_MOV;
          OP_MVN: ctrl_dec.exec_cmd = CMD_MVN;
          OP_ADD: ctrl_dec.exec_cmd = CMD_ADD;
          OP_ADC: ctrl_dec.exec_cmd = CMD_ADC;
          OP_SUB: ctrl_dec.exec_cmd = CMD_SUB;
          OP_SBC: ctrl_dec.exec_cmd = CMD_SBC;
          OP_AND: ctrl_dec.exec_cmd = CMD_AND;
          OP_ORR: ctrl_dec.exec_cmd = CMD_ORR;
          OP_EOR: ctrl_dec.exec_cmd = CMD_EOR;
          OP_CMP: begin
            ctrl_dec.exec_cmd = CMD_SUB;
            ctrl_dec.wb_en    = 1'b0;
            ctrl_dec.s        = 1'b1;
          end
          OP_TST: begin
            ctrl_dec.exec_cmd = CMD_AND;
            ctrl_dec.wb_en    = 1'b0;
            ctrl_dec.s        = 1'b1;
          end
          default: begin
            ctrl_dec.exec_cmd = CMD_NOP;
            ctrl_dec.wb_en    = 1'b0;
          end
        endcase
      end
      MODE_MEM: begin
        ctrl_dec.exec_cmd = CMD_ADD;
        ctrl_dec.mem_r_en = instr[20];
        ctrl_dec.wb_en    = instr[20];
        ctrl_dec.mem_w_en = ~instr[20];
      end
      MODE_BR: ctrl_dec.b = 1'b1;
      default: ctrl_dec = CTRL_BUBBLE;
    endcase
    if (!cond_pass) begin
      ctrl_dec = CTRL_BUBBLE;
    end
  end

  // A flushed slot still carries the raw fields and PC; only the control is squashed.
  assign ctrl_d = flush ? CTRL_BUBBLE : ctrl_dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= CTRL_BUBBLE;
      shift_q <= '0;
      imm24_q <= '0;
      dest_q  <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      pc_q    <= '0;
    end else if (flush || !freeze) begin
      ctrl_q  <= ctrl_d;
      shift_q <= instr[11:0];
      imm24_q <= instr[23:0];
      dest_q  <= instr[15:12];
      rn_q    <= instr[19:16];
      rm_q    <= instr[3:0];
      pc_q    <= pc_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
    end else if (ex_s) begin
      status_q <= alu_flags;
    end
  end

  assign ex_exec_cmd      = ctrl_q.exec_cmd;
  assign ex_mem_r_en      = ctrl_q.mem_r_en;
  assign ex_mem_w_en      = ctrl_q.mem_w_en;
  assign ex_wb_en         = ctrl_q.wb_en;
  assign ex_b             = ctrl_q.b;
  assign ex_s_out         = ctrl_q.s;
  assign ex_imm           = ctrl_q.imm;
  assign ex_shift_operand = shift_q;
  assign ex_imm24         = imm24_q;
  assign ex_dest          = dest_q;
  assign ex_rn            = rn_q;
  assign ex_rm            = rm_q;
  assign ex_pc            = pc_q;
  assign status           = status_q;
  assign c_in             = status_q[ST_C];

endmodule

// File: tb/tb_id_ex_control.sv
// Scoreboard bench for id_ex_control: directed test-plan cases plus randomized stimulus.
module tb_id_ex_control;

`ifdef ID_FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, pc_in;
  logic        freeze, flush, ex_s;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic [3:0]  ex_exec_cmd;
  logic        ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_b, ex_s_out, ex_imm;
  logic [11:0] ex_shift_operand;
  logic [23:0] ex_imm24;
  logic [3:0]  ex_dest, ex_rn, ex_rm;
  logic [31:0] ex_pc;
  logic [3:0]  status;
  logic        c_in;

  always #5 clk = ~clk;

  id_ex_control dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .pc_in(pc_in),
    .freeze(freeze), .flush(flush), .ex_s(ex_s),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .ex_exec_cmd(ex_exec_cmd), .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en),
    .ex_wb_en(ex_wb_en), .ex_b(ex_b), .ex_s_out(ex_s_out), .ex_imm(ex_imm),
    .ex_shift_operand(ex_shift_operand), .ex_imm24(ex_imm24),
    .ex_dest(ex_dest), .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_pc(ex_pc),
    .status(status), .c_in(c_in)
  );

  typedef struct packed {
    logic [3:0]  cmd;
    logic        mr, mw, wb, b, s, imm;
    logic [11:0] shift;
    logic [23:0] imm24;
    logic [3:0]  dest, rn, rm;
    logic [31:0] pc;
    logic [3:0]  st;
    logic        cin;
  } out_t;

  out_t        sb[$];
  out_t        prev;
  logic [3:0]  m_status;
  logic [3:0]  cmd_of [16];
  bit          known [16];
  int          passed = 0;
  int          total = 0;

  function automatic out_t actual();
    out_t a;
    a = '{ex_exec_cmd, ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_b, ex_s_out, ex_imm,
          ex_shift_operand, ex_imm24, ex_dest, ex_rn, ex_rm, ex_pc, status, c_in};
    return a;
  endfunction

  task automatic check(input string nm, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      out_t e;
      e = sb.pop_front();
      check("idex_scoreboard", actual(), e);
    end
  end

  function automatic bit cond_ok(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      0: return z;          1: return !z;
      2: return c;          3: return !c;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return c && !z;    9: return !c || z;
      10: return n == v;    11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input bit frz,
                       input bit fl, input bit es, input logic [3:0] alu);
    out_t e;
    logic [3:0] flags;
    logic [3:0] op;
    bit pass;
    instr = ins; pc_in = pc; freeze = frz; flush = fl; ex_s = es;
    {alu_n, alu_z, alu_c, alu_v} = alu;

    flags = (FWD && es) ? alu : m_status;
    pass  = cond_ok(ins[31:28], flags);
    op    = ins[24:21];
    e = '0;
    if (pass && !fl) begin
      if (ins[27:26] == 2'd0) begin
        e.cmd = known[op] ? cmd_of[op] : 4'd0;
        e.imm = ins[25];
        e.s   = (op == 4'd10 || op == 4'd8) ? 1'b1 : ins[20];
        e.wb  = known[op] && !(op == 4'd10 || op == 4'd8);
      end else if (ins[27:26] == 2'd1) begin
        e.cmd = 4'd2;
        e.mr  = ins[20];
        e.wb  = ins[20];
        e.mw  = !ins[20];
      end else if (ins[27:26] == 2'd2) begin
        e.b = 1'b1;
      end
    end
    e.shift = ins[11:0];
    e.imm24 = ins[23:0];
    e.dest  = ins[15:12];
    e.rn    = ins[19:16];
    e.rm    = ins[3:0];
    e.pc    = pc;
    if (frz && !fl) e = prev;
    prev = e;
    if (es) m_status = alu;
    e.st  = m_status;
    e.cin = m_status[1];
    sb.push_back(e);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", actual(), '0);
    step();
    rst_n = 1'b1;
    prev = '0;
    m_status = 4'd0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin known[i] = 1'b0; cmd_of[i] = 4'd0; end
    cmd_of[13] = 4'd1; cmd_of[15] = 4'd9; cmd_of[4] = 4'd2; cmd_of[5] = 4'd3;
    cmd_of[2]  = 4'd4; cmd_of[6]  = 4'd5; cmd_of[0] = 4'd6; cmd_of[12] = 4'd7;
    cmd_of[1]  = 4'd8; cmd_of[10] = 4'd4; cmd_of[8] = 4'd6;
    foreach (known[i]) known[i] = (i == 13 || i == 15 || i == 4 || i == 5 || i == 2 ||
                                   i == 6 || i == 0 || i == 12 || i == 1 || i == 10 || i == 8);

    rst_n = 1'b0; instr = '0; pc_in = '0; freeze = 0; flush = 0; ex_s = 0;
    {alu_n, alu_z, alu_c, alu_v} = 4'd0;
    prev = '0; m_status = 4'd0;
    step(); step();
    check("reset_state", actual(), '0);
    rst_n = 1'b1;

    drive(32'hE0921003, 32'h104, 0, 0, 0, 4'd0);
    step();
    check("adds_cmd", ex_exec_cmd, 4'b0010);
    check("adds_regs", {ex_wb_en, ex_s_out, ex_dest, ex_rn, ex_rm}, {2'b11, 12'h123});
    drive(32'hE5912004, 32'h108, 0, 0, 0, 4'd0);
    step();
    check("ldr_ctl", {ex_exec_cmd, ex_mem_r_en, ex_wb_en, ex_shift_operand}, {4'b0010, 2'b11, 12'h004});
    drive(32'hE5812004, 32'h10C, 0, 0, 0, 4'd0);
    step();
    check("str_ctl", {ex_mem_w_en, ex_wb_en}, 2'b10);
    drive(32'hE1A00000, 32'h110, 0, 0, 1, 4'b0110);
    step();
    check("status_load", status, 4'b0110);
    drive(32'h0A000004, 32'h114, 0, 0, 0, 4'd0);
    step();
    check("beq_taken", {ex_b, ex_imm24}, {1'b1, 24'h000004});
    drive(32'h1A000004, 32'h118, 0, 0, 0, 4'd0);
    step();
    check("bne_bubble", {ex_b, ex_exec_cmd, ex_wb_en}, 6'd0);
    drive(32'hE1A00000, 32'h11C, 0, 0, 1, 4'b0000);
    step();
    drive(32'h1A000004, 32'h120, 0, 0, 1, 4'b0100);
    step();
    check("same_cycle_flag_bne", ex_b, FWD ? 1'b0 : 1'b1);
    drive(32'hE0821003, 32'h124, 0, 0, 0, 4'd0);
    step();
    drive(32'hE5912004, 32'h128, 1, 0, 0, 4'd0);
    step();
    drive(32'hE1A00000, 32'h12C, 1, 0, 0, 4'd0);
    step();
    check("freeze_hold", {ex_exec_cmd, ex_pc}, {4'b0010, 32'h124});
    drive(32'hE0821003, 32'h130, 1, 1, 0, 4'd0);
    step();
    check("flush_over_freeze", {ex_exec_cmd, ex_wb_en, ex_pc}, {4'd0, 1'b0, 32'h130});

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 1) == 0) ins[31:28] = 4'hE;
      drive(ins, $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 2) == 0, 4'($urandom));
      step();
      if (i == 200) pulse_reset();
    end

    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_ex_control.md
# id_ex_control

Instruction decode control and ID/EX pipeline register for the ARM-subset core. Decodes the 32-bit instruction into the 4-bit execute command and control bits consumed by the EX-stage ALU. Evaluates the condition field against the NZCV status register it owns, which is updated from the ALU flags. Registers everything into the ID/EX stage with freeze/flush handling.

## Interface
- Parameters: none.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr` in 32: instruction from IF/ID.
- `pc_in` in 32: PC+4 from IF/ID.
- `freeze` in 1: hazard stall; hold the ID/EX register.
- `flush` in 1: taken branch; load a bubble.
- `ex_s` in 1: the instruction now in EX has S set; capture the ALU flags.
- `alu_n`, `alu_z`, `alu_c`, `alu_v` in 1 each: ALU flag outputs.
- `ex_exec_cmd` out 4: ALU command.
- `ex_mem_r_en`, `ex_mem_w_en`, `ex_wb_en`, `ex_b`, `ex_s_out`, `ex_imm` out 1 each: control bits.
- `ex_shift_operand` out 12: instr[11:0].
- `ex_imm24` out 24: instr[23:0].
- `ex_dest`, `ex_rn`, `ex_rm` out 4 each: instr[15:12], instr[19:16], instr[3:0].
- `ex_pc` out 32: registered `pc_in`.
- `status` out 4: {N,Z,C,V}.
- `c_in` out 1: `status[1]`, wired to the ALU carry-in.

## Operation
- **Mode** is instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined (bubble).
- **Data-processing map**, opcode = instr[24:21], giving exec_cmd:
  - MOV 1101→0001, MVN 1111→1001
  - ADD 0100→0010, ADC 0101→0011
  - SUB 0010→0100, SBC 0110→0101
  - AND 0000→0110, ORR 1100→0111, EOR 0001→1000
  - CMP 1010→0100, TST 1000→0110
  - Any other opcode→0000 with wb_en=0.
- **Data-processing control:** wb_en=1 except CMP/TST. s=instr[20], forced to 1 for CMP/TST. imm=instr[25].
- **Memory:** exec_cmd=0010.
  - instr[20]=1 (LDR): mem_r_en=1, wb_en=1.
  - instr[20]=0 (STR): mem_w_en=1.
  - s=0, imm=0.
- **Branch:** b=1, exec_cmd=0000, all other enables 0.
- **Conditions**, cond = instr[31:28]:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V)
  - AL 1, 1111 0.
- **Bubble:** all six control bits = 0 and exec_cmd = 0. Register/immediate fields and ex_pc still load.
  - Produced on condition fail, mode 11, or flush.
- **Status register:** loads {alu_n, alu_z, alu_c, alu_v} on every edge where ex_s=1. It is independent of freeze and flush.

## Timing
- **Reset:** asynchronous. Every output and the status register go to 0 while rst_n=0.
- **Latency:** one cycle; decode is combinational, outputs are registered on the rising edge.
- **Priority:** flush > freeze > load.
  - flush: load bubble.
  - freeze: hold all ID/EX outputs.
  - otherwise: load the decoded instruction.
- **Flag timing:** a status update from EX is visible on `status`/`c_in` the cycle after ex_s.
- **Reset deasserted mid-pipeline:** first edge loads normally; no residual state.

## Configuration
- `ID_FLAG_FWD_EN` defined: when ex_s=1, condition evaluation in the same cycle uses the incoming ALU flags instead of the status register.
- Undefined: condition evaluation uses the registered status only. The hazard unit must stall one cycle after a flag-setting instruction.

## Structure
- **Shared package `arm_pkg`:**
  - exec_cmd localparams (CMD_MOV … CMD_NOP)
  - opcode localparams and condition localparams
  - mode constants
  - status bit indices
- **Sub-module `cond_check`:** combinational; 4-bit cond + 4-bit NZCV → pass.

## Test plan
- ADDS R1,R2,R3, `instr`=0xE0921003 → next edge: exec_cmd=0010, wb_en=1, s_out=1, dest=1, rn=2, rm=3.
- LDR R2,[R1,#4], `instr`=0xE5912004 → exec_cmd=0010, mem_r_en=1, wb_en=1, shift_operand=0x004. STR 0xE5812004 → mem_w_en=1, wb_en=0.
- ex_s=1 with N,Z,C,V=0,1,1,0 → status=0110. Then BEQ 0x0A000004 → ex_b=1, imm24=0x000004. BNE 0x1A000004 → bubble.
- Status=0000, ex_s=1 with Z=1, same-cycle BNE 0x1A000004:
  - with ID_FLAG_FWD_EN → ex_b=0;
  - without → ex_b=1.
- ADD loaded, then freeze=1 for 2 cycles with new instr → outputs unchanged. Then freeze=1 and flush=1 together → bubble.
- Mid-stream, rst_n pulsed low between edges → outputs and status go to 0 immediately, without waiting for a clock edge.
